// File: rtl/surf_scaler_gate_sequencer_if.sv
// surf_scaler_gate_sequencer_if
//   Register-bus read port of the scaler gate sequencer.
//   Signals are named from the sequencer's point of view.
//     rd_req_i   single-cycle read strobe
//     rd_addr_i  read address
//     rd_ack_o   one-cycle acknowledge, one cycle after the strobe
//     rd_data_o  read data, valid with rd_ack_o, held otherwise
//   master : readout side (drives request), slave : sequencer side.
interface surf_scaler_gate_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
);
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_ack_o;
  logic [CNT_W-1:0]  rd_data_o;

  modport master (output rd_req_i, rd_addr_i, input  rd_ack_o, rd_data_o);
  modport slave  (input  rd_req_i, rd_addr_i, output rd_ack_o, rd_data_o);
endinterface

// File: rtl/surf_scaler_gate_sequencer.sv
// surf_scaler_gate_sequencer
//   Counts rising edges on each scaler bit over a gate period and publishes
//   the counts into shadow registers at end of period (TURF ref pulse edge or
//   internal timer). Shadows and the measured period length are served over a
//   req/ack read port. Single clock domain (mclk, 33 MHz).
//
//   Ports:
//     mclk_i       master clock
//     rst_n_i      async active-low reset
//     enable_i     1 = run, 0 = force DISABLED
//     use_ref_i    1 = period ends on ref pulse edge, 0 = internal timer
//     period_i     timer period in cycles, 0 means 65536
//     scal_i       scaler bits, one per channel
//     ref_pulse_i  registered TURF reference pulse
//     rd_if        read port (slave modport)
//     update_o     one-cycle pulse after shadows are published
//     state_o      FSM state: 0 DISABLED, 1 ARM, 2 COUNT
//
//   Read map: addr < NUM_CH -> shadow[addr], NUM_CH -> period length,
//   NUM_CH+1 / NUM_CH+2 -> overflow flags (only with the option), else 0.
//
//   Optional feature macro: SCALER_OVF_FLAG_EN (per-channel sticky overflow
//   flags latched at end of period). Undefined by default.

// Per-channel edge counter with saturating count and shadow register.
module surf_scaler_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             scal_i,
  input  logic             run_i,     // COUNT and enabled; 0 clears counter
  input  logic             eop_i,     // end-of-period cycle
  input  logic             flg_clr_i, // DISABLED: clear shadow flag
  output logic [CNT_W-1:0] shadow_o,
  output logic             flag_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev_q;
  logic             edge_w;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign edge_w  = scal_i & ~prev_q;
  assign cnt_inc = (edge_w && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      shadow_o <= '0;
    end else begin
      prev_q <= scal_i;
      if (!run_i) begin
        cnt_q <= '0;
      end else if (eop_i) begin
        // EOP-cycle edge still belongs to the ending period
        shadow_o <= cnt_inc;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

`ifdef SCALER_OVF_FLAG_EN
  // Overflow = an edge arriving while the counter is already pinned at max.
  logic ovf_q;
  logic ovf_hit;
  assign ovf_hit = edge_w && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q  <= 1'b0;
      flag_o <= 1'b0;
    end else begin
      if (!run_i)      ovf_q <= 1'b0;
      else if (eop_i)  ovf_q <= 1'b0;
      else             ovf_q <= ovf_q | ovf_hit;
      if (flg_clr_i)   flag_o <= 1'b0;
      else if (eop_i)  flag_o <= ovf_q | ovf_hit;
    end
  end
`else
  logic unused_flg_clr;
  assign unused_flg_clr = flg_clr_i;
  assign flag_o = 1'b0;
`endif
endmodule

module surf_scaler_gate_sequencer #(
  parameter int NUM_CH = 22,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                  mclk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  use_ref_i,
  input  logic [15:0]           period_i,
  input  logic [NUM_CH-1:0]     scal_i,
  input  logic                  ref_pulse_i,
  surf_scaler_gate_sequencer_if.slave rd_if,
  output logic                  update_o,
  output logic [1:0]            state_o
);
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARM      = 2'd1,
    ST_COUNT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]      CNT_MAX32 = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << CNT_W) - 32'd1);

  state_t                         state_q;
  logic                           ref_prev_q;
  logic [15:0]                    timer_q;
  logic [CNT_W-1:0]               period_len_q;
  logic                           update_q;
  logic                           ack_q;
  logic [CNT_W-1:0]               data_q;

  logic                           ref_edge;
  logic                           run;
  logic                           eop;
  logic [31:0]                    tp1;
  logic [CNT_W-1:0]               plen_sat;
  logic [NUM_CH-1:0][CNT_W-1:0]   shadow;
  logic [NUM_CH-1:0]              flags;
  logic [31:0]                    addr_w;
  logic [CNT_W-1:0]               rd_val;

  assign ref_edge = ref_pulse_i & ~ref_prev_q;
  assign run      = (state_q == ST_COUNT) && enable_i;
  // period_i == 0 wraps to 16'hFFFF, giving a 65536-cycle period
  assign eop      = run && (use_ref_i ? ref_edge : (timer_q == period_i - 16'd1));

  assign tp1      = 32'(timer_q) + 32'd1;
  assign plen_sat = (tp1 > CNT_MAX32) ? CNT_MAX : tp1[CNT_W-1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    surf_scaler_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_i     (mclk_i),
      .rst_n_i   (rst_n_i),
      .scal_i    (scal_i[g]),
      .run_i     (run),
      .eop_i     (eop),
      .flg_clr_i (state_q == ST_DISABLED),
      .shadow_o  (shadow[g]),
      .flag_o    (flags[g])
    );
  end

  // Read mux works on the registered shadows, so a read in the EOP cycle
  // returns the pre-update value.
  assign addr_w = 32'(rd_if.rd_addr_i);

`ifdef SCALER_OVF_FLAG_EN
  logic [NUM_CH+2*CNT_W-1:0] flag_ext;
  assign flag_ext = {{(2*CNT_W){1'b0}}, flags};
`else
  logic unused_flags;
  assign unused_flags = ^flags;
`endif

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (addr_w == 32'(i)) rd_val = shadow[i];
    if (addr_w == 32'(NUM_CH)) rd_val = period_len_q;
`ifdef SCALER_OVF_FLAG_EN
    if (addr_w == 32'(NUM_CH + 1)) rd_val = flag_ext[CNT_W-1:0];
    if (addr_w == 32'(NUM_CH + 2)) rd_val = flag_ext[2*CNT_W-1:CNT_W];
`endif
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_DISABLED;
      ref_prev_q   <= 1'b0;
      timer_q      <= '0;
      period_len_q <= '0;
      update_q     <= 1'b0;
      ack_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      ref_prev_q <= ref_pulse_i;
      update_q   <= eop;
      ack_q      <= rd_if.rd_req_i;
      if (rd_if.rd_req_i) data_q <= rd_val;

      // Timer saturates so an overlong ref period reports max length
      if (!run)                   timer_q <= '0;
      else if (eop)               timer_q <= '0;
      else if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;

      if (eop) period_len_q <= plen_sat;

      case (state_q)
        ST_DISABLED: if (enable_i) state_q <= use_ref_i ? ST_ARM : ST_COUNT;
        ST_ARM: begin
          // the arming edge starts the period; its own edges are not counted
          if (!enable_i)     state_q <= ST_DISABLED;
          else if (ref_edge) state_q <= ST_COUNT;
        end
        ST_COUNT:    if (!enable_i) state_q <= ST_DISABLED;
        default:     state_q <= ST_DISABLED;
      endcase
    end
  end

  assign state_o         = state_q;
  assign update_o        = update_q;
  assign rd_if.rd_ack_o  = ack_q;
  assign rd_if.rd_data_o = data_q;
endmodule

// File: tb/tb_surf_scaler_gate_sequencer.sv
// Directed bench for surf_scaler_gate_sequencer. A second instance with
// CNT_W=4 shares all stimulus and is used for saturation/overflow checks.
module tb_surf_scaler_gate_sequencer;
  localparam int NUM_CH = 22;

  logic              mclk = 1'b0;
  logic              rst_n;
  logic              enable, use_ref, ref_pulse;
  logic [15:0]       period;
  logic [NUM_CH-1:0] scal;
  logic              update, update4;
  logic [1:0]        state, state4;
  int                n_checks = 0;
  int                n_fail   = 0;

  surf_scaler_gate_sequencer_if #(.ADDR_W(6), .CNT_W(16)) rif ();
  surf_scaler_gate_sequencer_if #(.ADDR_W(6), .CNT_W(4))  rif4 ();
  assign rif4.rd_req_i  = rif.rd_req_i;
  assign rif4.rd_addr_i = rif.rd_addr_i;

  always #15 mclk = ~mclk;

  surf_scaler_gate_sequencer #(.NUM_CH(NUM_CH), .CNT_W(16), .ADDR_W(6)) dut (
    .mclk_i(mclk), .rst_n_i(rst_n), .enable_i(enable), .use_ref_i(use_ref),
    .period_i(period), .scal_i(scal), .ref_pulse_i(ref_pulse),
    .rd_if(rif), .update_o(update), .state_o(state));

  surf_scaler_gate_sequencer #(.NUM_CH(NUM_CH), .CNT_W(4), .ADDR_W(6)) dut4 (
    .mclk_i(mclk), .rst_n_i(rst_n), .enable_i(enable), .use_ref_i(use_ref),
    .period_i(period), .scal_i(scal), .ref_pulse_i(ref_pulse),
    .rd_if(rif4), .update_o(update4), .state_o(state4));

  // Single read: strobe one cycle, return ack/data of both instances and
  // the ack level one cycle later (must be back to 0).
  task automatic rd(input logic [5:0] addr, output logic ack, output logic [15:0] data,
                    output logic [3:0] data4, output logic ack_after);
    rif.rd_req_i = 1'b1; rif.rd_addr_i = addr;
    @(negedge mclk);
    rif.rd_req_i = 1'b0;
    ack = rif.rd_ack_o; data = rif.rd_data_o; data4 = rif4.rd_data_o;
    @(negedge mclk);
    ack_after = rif.rd_ack_o;
  endtask

  // Fresh timer-mode period of 100 cycles with nedges rising edges on ch,
  // optionally an extra edge and/or a read of ch3 in the EOP cycle.
  task automatic run_period(input int ch, input int nedges, input bit eop_edge,
                            input bit rd_eop, output logic eop_ack,
                            output logic [15:0] eop_data);
    enable = 1'b0; use_ref = 1'b0; period = 16'd100; scal = '0;
    @(negedge mclk); @(negedge mclk);
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge mclk);
      scal[ch] = (c < 2*nedges) ? c[0] : (eop_edge && c == 99);
      if (c == 99) begin
        n_checks++;
        if (update !== 1'b0) begin n_fail++; $display("FAIL upd_early: got %b want 0", update); end
        if (rd_eop) begin rif.rd_req_i = 1'b1; rif.rd_addr_i = 6'd3; end
      end
    end
    @(negedge mclk);
    scal[ch] = 1'b0; rif.rd_req_i = 1'b0;
    eop_ack = rif.rd_ack_o; eop_data = rif.rd_data_o;
    n_checks++;
    if (update !== 1'b1) begin n_fail++; $display("FAIL upd_pulse: got %b want 1", update); end
    @(negedge mclk);
    n_checks++;
    if (update !== 1'b0) begin n_fail++; $display("FAIL upd_width: got %b want 0", update); end
  endtask

  task automatic test_reset();
    logic a, aa; logic [15:0] d; logic [3:0] d4;
    n_checks++;
    if (state !== 2'd0 || state4 !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_checks++;
    if (rif.rd_ack_o !== 1'b0 || rif.rd_data_o !== 16'd0) begin n_fail++; $display("FAIL rst_rd: ack %b data %0d want 0/0", rif.rd_ack_o, rif.rd_data_o); end
    n_checks++;
    if (update !== 1'b0) begin n_fail++; $display("FAIL rst_upd: got %b want 0", update); end
    rst_n = 1'b1; enable = 1'b1; use_ref = 1'b0; period = 16'd100;
    for (int c = 0; c < 8; c++) begin @(negedge mclk); scal[3] = c[0]; end
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL cnt_state: got %0d want 2", state); end
    rif.rd_req_i = 1'b1; rif.rd_addr_i = 6'd3;
    @(negedge mclk);
    rif.rd_req_i = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", state); end
    n_checks++;
    if (rif.rd_ack_o !== 1'b0 || update !== 1'b0) begin n_fail++; $display("FAIL midrst_out: ack %b upd %b want 0/0", rif.rd_ack_o, update); end
    scal = '0;
    @(negedge mclk); rst_n = 1'b1;
    @(negedge mclk); @(negedge mclk);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL rel_state: got %0d want 2", state); end
    rd(6'd0, a, d, d4, aa);
    n_checks++;
    if (a !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL rst_rd0: ack %b data %0d want 1/0", a, d); end
  endtask

  task automatic test_timer_mode();
    logic a, aa, ea; logic [15:0] d, ed; logic [3:0] d4;
    run_period(3, 10, 1'b0, 1'b0, ea, ed);
    rd(6'd3, a, d, d4, aa);
    n_checks++;
    if (a !== 1'b1 || d !== 16'd10) begin n_fail++; $display("FAIL tmr_sh3: ack %b data %0d want 1/10", a, d); end
    rd(6'(NUM_CH), a, d, d4, aa);
    n_checks++;
    if (d !== 16'd100) begin n_fail++; $display("FAIL tmr_plen: got %0d want 100", d); end
    run_period(3, 10, 1'b1, 1'b0, ea, ed);
    rd(6'd3, a, d, d4, aa);
    n_checks++;
    if (d !== 16'd11) begin n_fail++; $display("FAIL tmr_eopedge: got %0d want 11", d); end
  endtask

  task automatic test_ref_mode();
    logic a, aa; logic [15:0] d; logic [3:0] d4;
    enable = 1'b0; use_ref = 1'b1; ref_pulse = 1'b0; scal = '0;
    @(negedge mclk); @(negedge mclk);
    enable = 1'b1;
    @(negedge mclk); @(negedge mclk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL ref_arm: got %0d want 1", state); end
    ref_pulse = 1'b1; scal[5] = 1'b1;      // edge in arming cycle: not counted
    @(negedge mclk);
    ref_pulse = 1'b0; scal[5] = 1'b0;
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL ref_count: got %0d want 2", state); end
    for (int k = 1; k < 500; k++) begin
      @(negedge mclk);
      scal[5] = (k == 1);
      if (k == 499) ref_pulse = 1'b1;
    end
    @(negedge mclk);
    ref_pulse = 1'b0;
    n_checks++;
    if (update !== 1'b1) begin n_fail++; $display("FAIL ref_upd: got %b want 1", update); end
    rd(6'(NUM_CH), a, d, d4, aa);
    n_checks++;
    if (a !== 1'b1 || d !== 16'd500) begin n_fail++; $display("FAIL ref_plen: ack %b data %0d want 1/500", a, d); end
    n_checks++;
    if (aa !== 1'b0) begin n_fail++; $display("FAIL ref_ackw: got %b want 0", aa); end
    rd(6'd5, a, d, d4, aa);
    n_checks++;
    if (d !== 16'd1) begin n_fail++; $display("FAIL ref_sh5: got %0d want 1", d); end
  endtask

  task automatic test_saturation();
    logic a, aa, ea; logic [15:0] d, ed; logic [3:0] d4, fexp;
    run_period(0, 20, 1'b0, 1'b0, ea, ed);
    rd(6'd0, a, d, d4, aa);
    n_checks++;
    if (d4 !== 4'd15) begin n_fail++; $display("FAIL sat_sh0: got %0d want 15", d4); end
    n_checks++;
    if (d !== 16'd20) begin n_fail++; $display("FAIL nosat_sh0: got %0d want 20", d); end
`ifdef SCALER_OVF_FLAG_EN
    fexp = 4'd1;
`else
    fexp = 4'd0;
`endif
    rd(6'(NUM_CH + 1), a, d, d4, aa);
    n_checks++;
    if (a !== 1'b1 || d4 !== fexp) begin n_fail++; $display("FAIL sat_flag: ack %b data %0d want 1/%0d", a, d4, fexp); end
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL noovf_flag: got %0d want 0", d); end
  endtask

  task automatic test_collision();
    logic a, aa, ea, a1, a2, a3; logic [15:0] d, ed, d1, d2; logic [3:0] d4;
    run_period(3, 7, 1'b0, 1'b0, ea, ed);
    run_period(3, 4, 1'b0, 1'b1, ea, ed);
    n_checks++;
    if (ea !== 1'b1 || ed !== 16'd7) begin n_fail++; $display("FAIL col_old: ack %b data %0d want 1/7", ea, ed); end
    rd(6'd3, a, d, d4, aa);
    n_checks++;
    if (d !== 16'd4) begin n_fail++; $display("FAIL col_new: got %0d want 4", d); end
    // back-to-back strobes
    rif.rd_req_i = 1'b1; rif.rd_addr_i = 6'd3;
    @(negedge mclk);
    rif.rd_addr_i = 6'(NUM_CH);
    a1 = rif.rd_ack_o; d1 = rif.rd_data_o;
    @(negedge mclk);
    rif.rd_req_i = 1'b0;
    a2 = rif.rd_ack_o; d2 = rif.rd_data_o;
    @(negedge mclk);
    a3 = rif.rd_ack_o;
    n_checks++;
    if (a1 !== 1'b1 || d1 !== 16'd4) begin n_fail++; $display("FAIL b2b_1: ack %b data %0d want 1/4", a1, d1); end
    n_checks++;
    if (a2 !== 1'b1 || d2 !== 16'd100 || a3 !== 1'b0) begin n_fail++; $display("FAIL b2b_2: ack %b data %0d ack3 %b want 1/100/0", a2, d2, a3); end
    rd(6'd63, a, d, d4, aa);
    n_checks++;
    if (a !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL bad_addr: ack %b data %0d want 1/0", a, d); end
    n_checks++;
    if (rif.rd_data_o !== 16'd0) begin n_fail++; $display("FAIL data_hold: got %0d want 0", rif.rd_data_o); end
  endtask

  task automatic test_disable();
    logic a, aa, ea; logic [15:0] d, ed; logic [3:0] d4;
    enable = 1'b0; use_ref = 1'b0; period = 16'd100; scal = '0;
    @(negedge mclk); @(negedge mclk);
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin @(negedge mclk); scal[3] = (c < 12) ? c[0] : 1'b0; end
    enable = 1'b0;
    @(negedge mclk);
    n_checks++;
    if (state !== 2'd0 || update !== 1'b0) begin n_fail++; $display("FAIL dis_state: state %0d upd %b want 0/0", state, update); end
    rd(6'd3, a, d, d4, aa);
    n_checks++;
    if (d !== 16'd4) begin n_fail++; $display("FAIL dis_keep: got %0d want 4", d); end
    run_period(3, 3, 1'b0, 1'b0, ea, ed);
    rd(6'd3, a, d, d4, aa);
    n_checks++;
    if (d !== 16'd3) begin n_fail++; $display("FAIL reen_zero: got %0d want 3", d); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; use_ref = 1'b0; ref_pulse = 1'b0;
    period = 16'd100; scal = '0;
    rif.rd_req_i = 1'b0; rif.rd_addr_i = '0;
    @(negedge mclk); @(negedge mclk);
    test_reset();
    test_timer_mode();
    test_ref_mode();
    test_saturation();
    test_collision();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
